// File: rtl/control_pipe_if.sv
// Control-pipe bus: ID-stage instruction stream in, EX/MEM/WB control bundle out.
interface control_pipe_if;
  logic [31:0] in_instruction;
  logic        in_valid;
  logic        in_stall_ext;
  logic        in_flush;

  logic        ID_stall;
  logic        EX_valid;
  logic        EX_alu_src;
  logic [2:0]  EX_alu_op;
  logic        EX_mul_busy;
  logic        MEM_valid;
  logic        MEM_mem_write;
  logic        MEM_mem_read;
  logic        MEM_branch_inst;
  logic        WB_valid;
  logic        WB_write_mem_to_reg;
  logic        WB_write_enable;

  modport master (
    output in_instruction, in_valid, in_stall_ext, in_flush,
    input  ID_stall, EX_valid, EX_alu_src, EX_alu_op, EX_mul_busy,
    input  MEM_valid, MEM_mem_write, MEM_mem_read, MEM_branch_inst,
    input  WB_valid, WB_write_mem_to_reg, WB_write_enable
  );

  modport slave (
    input  in_instruction, in_valid, in_stall_ext, in_flush,
    output ID_stall, EX_valid, EX_alu_src, EX_alu_op, EX_mul_busy,
    output MEM_valid, MEM_mem_write, MEM_mem_read, MEM_branch_inst,
    output WB_valid, WB_write_mem_to_reg, WB_write_enable
  );
endinterface

// File: rtl/control_pipe.sv
// Pipelined control unit: decodes the ID instruction and carries the control bundle
// through EX/MEM/WB, with load-use stall, flush, external stall and a MUL sequencer.
module control_pipe #(
  parameter int unsigned MUL_LATENCY   = 3,
  parameter bit          ENABLE_MUL    = 1'b1,
  parameter bit          ENABLE_HAZARD = 1'b1
) (
  input logic           clk,
  input logic           reset,
  control_pipe_if.slave bus
);

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam bit          MulSeq = ENABLE_MUL && (MUL_LATENCY > 1);
  localparam int unsigned CntW   = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MUL_LATENCY - 1);

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       mem_to_reg;
    logic       write_enable;
    logic [4:0] rd;
  } ex_t;

  typedef struct packed {
    logic valid;
    logic mem_write;
    logic mem_read;
    logic branch;
    logic mem_to_reg;
    logic write_enable;
  } mem_t;

  typedef struct packed {
    logic valid;
    logic mem_to_reg;
    logic write_enable;
  } wb_t;

  typedef enum logic [0:0] {StIdle, StMulBusy} state_t;

  function automatic mem_t to_mem(ex_t e);
    mem_t m;
    m.valid        = e.valid;
    m.mem_write    = e.mem_write;
    m.mem_read     = e.mem_read;
    m.branch       = e.branch;
    m.mem_to_reg   = e.mem_to_reg;
    m.write_enable = e.write_enable;
    return m;
  endfunction

  function automatic wb_t to_wb(mem_t m);
    wb_t w;
    w.valid        = m.valid;
    w.mem_to_reg   = m.mem_to_reg;
    w.write_enable = m.write_enable;
    return w;
  endfunction

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            unused_funct3;
  logic            uses_rs2;
  logic            load_use;
  logic            mul_busy;
  logic            id_is_mul;
  ex_t             id_ctrl;
  ex_t             ex_q, ex_d;
  mem_t            mem_q, mem_d;
  wb_t             wb_q, wb_d;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign opcode        = bus.in_instruction[6:0];
  assign funct7        = bus.in_instruction[31:25];
  assign rs1           = bus.in_instruction[19:15];
  assign rs2           = bus.in_instruction[24:20];
  assign unused_funct3 = ^bus.in_instruction[14:12];

  always_comb begin
    id_ctrl   = '0;
    id_is_mul = 1'b0;
    if (bus.in_valid) begin
      id_ctrl.valid = 1'b1;
      id_ctrl.rd    = bus.in_instruction[11:7];
      case (opcode)
        OpRtype: begin
          id_ctrl.write_enable = 1'b1;
          id_ctrl.alu_op       = 3'b010;
          if (ENABLE_MUL && (funct7 == 7'b0000001)) begin
            id_ctrl.alu_op = 3'b101;
            id_is_mul      = 1'b1;
          end
        end
        OpLoad: begin
          id_ctrl.alu_src      = 1'b1;
          id_ctrl.mem_read     = 1'b1;
          id_ctrl.mem_to_reg   = 1'b1;
          id_ctrl.write_enable = 1'b1;
          id_ctrl.alu_op       = 3'b000;
        end
        OpStore: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.mem_write = 1'b1;
          id_ctrl.alu_op    = 3'b000;
        end
        OpAluImm: begin
          id_ctrl.alu_src      = 1'b1;
          id_ctrl.write_enable = 1'b1;
          id_ctrl.alu_op       = 3'b011;
        end
        OpLui: begin
          id_ctrl.alu_src      = 1'b1;
          id_ctrl.write_enable = 1'b1;
          id_ctrl.alu_op       = 3'b100;
        end
        OpBranch: begin
          id_ctrl.branch = 1'b1;
          id_ctrl.alu_op = 3'b001;
        end
        default: id_ctrl = '0;
      endcase
    end
  end

  assign uses_rs2 = (opcode == OpRtype) || (opcode == OpStore) || (opcode == OpBranch);
  assign load_use = ENABLE_HAZARD && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == rs1) || ((ex_q.rd == rs2) && uses_rs2));
  assign mul_busy = (state_q == StMulBusy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // External stall leaves every *_d at its hold value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    if (!bus.in_stall_ext) begin
      wb_d = to_wb(mem_q);
      if (bus.in_flush) begin
        ex_d    = '0;
        mem_d   = '0;
        state_d = StIdle;
        cnt_d   = '0;
      end else if (mul_busy) begin
        // The MUL sits in EX; leaving busy one cycle early lets it advance from IDLE.
        mem_d = '0;
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end else if (load_use) begin
        ex_d  = '0;
        mem_d = to_mem(ex_q);
      end else begin
        ex_d  = id_ctrl;
        mem_d = to_mem(ex_q);
        if (MulSeq && id_is_mul) begin
          state_d = StMulBusy;
          cnt_d   = CntLoad;
        end
      end
    end
  end

  always_comb begin
    bus.ID_stall            = !reset &&
                              (bus.in_stall_ext || (!bus.in_flush && (mul_busy || load_use)));
    bus.EX_valid            = ex_q.valid;
    bus.EX_alu_src          = ex_q.alu_src;
    bus.EX_alu_op           = ex_q.alu_op;
    bus.EX_mul_busy         = mul_busy;
    bus.MEM_valid           = mem_q.valid;
    bus.MEM_mem_write       = mem_q.mem_write;
    bus.MEM_mem_read        = mem_q.mem_read;
    bus.MEM_branch_inst     = mem_q.branch;
    bus.WB_valid            = wb_q.valid;
    bus.WB_write_mem_to_reg = wb_q.mem_to_reg;
    bus.WB_write_enable     = wb_q.valid && wb_q.write_enable;
  end

endmodule

// File: tb/tb_control_pipe.sv
// Randomised bench for control_pipe against an instruction-level pipeline model.
module tb_control_pipe;

  localparam int MulLat = 3;

  typedef struct packed {
    bit       valid;
    bit       alu_src;
    bit [2:0] alu_op;
    bit       mw;
    bit       mr;
    bit       br;
    bit       m2r;
    bit       we;
    bit       mul;
    bit [4:0] rd;
  } slot_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  slot_t m_ex, m_mem, m_wb;
  int    m_age;

  control_pipe_if bus();
  control_pipe_if bus_nm();

  control_pipe #(.MUL_LATENCY(MulLat), .ENABLE_MUL(1'b1), .ENABLE_HAZARD(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  control_pipe #(.MUL_LATENCY(MulLat), .ENABLE_MUL(1'b0), .ENABLE_HAZARD(1'b1)) dut_nm (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit uses_rs2(bit [6:0] op);
    return op == 7'h33 || op == 7'h23 || op == 7'h63;
  endfunction

  function automatic slot_t dec(bit [31:0] ins, bit v);
    slot_t s;
    s = '0;
    if (!v) return s;
    s.valid = 1'b1;
    s.rd    = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        s.we  = 1'b1;
        s.mul = (ins[31:25] == 7'h01);
        s.alu_op = s.mul ? 3'd5 : 3'd2;
      end
      7'h03: begin s.alu_src = 1'b1; s.mr = 1'b1; s.m2r = 1'b1; s.we = 1'b1; end
      7'h23: begin s.alu_src = 1'b1; s.mw = 1'b1; end
      7'h13: begin s.alu_src = 1'b1; s.we = 1'b1; s.alu_op = 3'd3; end
      7'h37: begin s.alu_src = 1'b1; s.we = 1'b1; s.alu_op = 3'd4; end
      7'h63: begin s.br = 1'b1; s.alu_op = 3'd1; end
      default: s = '0;
    endcase
    return s;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input bit [31:0] ins, input bit v, input bit st, input bit fl,
                      input bit rs);
    slot_t id;
    bit    busy;
    bit    lu;
    @(negedge clk);
    bus.in_instruction = ins;
    bus.in_valid       = v;
    bus.in_stall_ext   = st;
    bus.in_flush       = fl;
    reset              = rs;
    #1;
    if (rs) begin
      m_ex  = '0;
      m_mem = '0;
      m_wb  = '0;
      m_age = 0;
    end
    id   = dec(ins, v);
    busy = (MulLat > 1) && m_ex.valid && m_ex.mul && (m_age < MulLat);
    lu   = m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) &&
           ((m_ex.rd == ins[19:15]) || ((m_ex.rd == ins[24:20]) && uses_rs2(ins[6:0])));
    check("id_stall", 32'(bus.ID_stall), 32'(!rs && (st || (!fl && (busy || lu)))));
    check("ex", 32'({bus.EX_valid, bus.EX_alu_src, bus.EX_alu_op, bus.EX_mul_busy}),
          32'({m_ex.valid, m_ex.alu_src, m_ex.alu_op, busy}));
    check("mem", 32'({bus.MEM_valid, bus.MEM_mem_write, bus.MEM_mem_read, bus.MEM_branch_inst}),
          32'({m_mem.valid, m_mem.mw, m_mem.mr, m_mem.br}));
    check("wb", 32'({bus.WB_valid, bus.WB_write_mem_to_reg, bus.WB_write_enable}),
          32'({m_wb.valid, m_wb.m2r, m_wb.we && m_wb.valid}));
    if (!rs && !st) begin
      m_wb = m_mem;
      if (fl) begin
        m_mem = '0;
        m_ex  = '0;
        m_age = 0;
      end else if (busy) begin
        m_mem = '0;
        m_age++;
      end else if (lu) begin
        m_mem = m_ex;
        m_ex  = '0;
        m_age = 0;
      end else begin
        m_mem = m_ex;
        m_ex  = id;
        m_age = 1;
      end
    end
  endtask

  task automatic run(input bit [31:0] ins, input int n);
    step(ins, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < n; i++) step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit [31:0] lw_x5, add_x6, lw_x0, mul_x3, beq, sw, lui, addi, lw_x7, ins;
    bit [6:0]  ops[7];
    bit [6:0]  op;
    bit [6:0]  f7;

    n_total = 0;
    n_bad   = 0;
    m_ex    = '0;
    m_mem   = '0;
    m_wb    = '0;
    m_age   = 0;
    reset   = 1'b1;
    bus.in_instruction    = '0;
    bus.in_valid          = 1'b0;
    bus.in_stall_ext      = 1'b0;
    bus.in_flush          = 1'b0;
    bus_nm.in_instruction = '0;
    bus_nm.in_valid       = 1'b0;
    bus_nm.in_stall_ext   = 1'b0;
    bus_nm.in_flush       = 1'b0;

    lw_x5  = {12'd0, 5'd1, 3'b010, 5'd5, 7'h03};
    add_x6 = {7'h00, 5'd2, 5'd5, 3'b000, 5'd6, 7'h33};
    lw_x0  = {12'd0, 5'd1, 3'b010, 5'd0, 7'h03};
    mul_x3 = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    beq    = {7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63};
    sw     = {7'h00, 5'd2, 5'd1, 3'b010, 5'd0, 7'h23};
    lui    = {20'h12345, 5'd1, 7'h37};
    addi   = {12'd5, 5'd1, 3'b000, 5'd2, 7'h13};
    lw_x7  = {12'd4, 5'd1, 3'b010, 5'd7, 7'h03};
    ops    = '{7'h33, 7'h03, 7'h23, 7'h13, 7'h37, 7'h63, 7'h7f};

    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while a load sits in MEM.
    step(lw_x5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(32'h0, 2);

    // Load-use, then the same pair with rd = x0.
    step(lw_x5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(add_x6, 1'b1, 1'b0, 1'b0, 1'b0);
    run(add_x6, 5);
    step(lw_x0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(add_x6, 5);

    // Multi-cycle MUL, then flush with beq in MEM while the MUL is busy.
    run(mul_x3, 7);
    step(beq, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mul_x3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(add_x6, 1'b1, 1'b0, 1'b1, 1'b0);
    run(32'h0, 4);

    // External stall with a store in MEM.
    step(sw, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(addi, 1'b1, 1'b1, 1'b0, 1'b0);
    run(32'h0, 3);

    // Back-to-back lui/addi/sw/lw/beq.
    step(lui, 1'b1, 1'b0, 1'b0, 1'b0);
    step(addi, 1'b1, 1'b0, 1'b0, 1'b0);
    step(sw, 1'b1, 1'b0, 1'b0, 1'b0);
    step(lw_x7, 1'b1, 1'b0, 1'b0, 1'b0);
    run(beq, 5);

    for (int n = 0; n < 3000; n++) begin
      op  = ops[$urandom_range(0, 6)];
      f7  = (op == 7'h33 && $urandom_range(0, 1) == 1) ? 7'h01 : 7'h00;
      ins = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 3)), op};
      step(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 12) == 0, $urandom_range(0, 99) == 0);
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Without the MUL option a MUL is a plain single-cycle R-type.
    @(negedge clk);
    bus_nm.in_instruction = mul_x3;
    bus_nm.in_valid       = 1'b1;
    @(negedge clk);
    #1;
    check("nm_ex_valid", 32'(bus_nm.EX_valid), 32'd1);
    check("nm_ex_alu_op", 32'(bus_nm.EX_alu_op), 32'd2);
    check("nm_mul_busy", 32'(bus_nm.EX_mul_busy), 32'd0);
    check("nm_id_stall", 32'(bus_nm.ID_stall), 32'd0);
    bus_nm.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("nm_mem_valid", 32'(bus_nm.MEM_valid), 32'd1);
    check("nm_ex_empty", 32'(bus_nm.EX_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
